// File: rtl/bht_spec.sv
// Branch history tracker: keeps the history patterns that index the PHT.
// Provides local (per-entry) or global history, with optional speculative
// update and mispredict repair. Instead of a bulk-array reset it runs a
// sequential clear sweep, which a flush also restarts.
module bht_spec #(
    parameter int IWIDTH = 6,
    parameter int HWIDTH = 4,
    parameter int MODE   = 0,
    parameter int SPEC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_flush,
    output logic              o_ready,
    input  logic [IWIDTH-1:0] i_lookup_index,
    output logic [HWIDTH-1:0] o_lookup_hist,
    input  logic              i_spec_valid,
    input  logic [IWIDTH-1:0] i_spec_index,
    input  logic              i_spec_taken,
    input  logic              i_res_valid,
    input  logic [IWIDTH-1:0] i_res_index,
    input  logic              i_res_taken,
    input  logic              i_res_mispredict,
    input  logic [HWIDTH-1:0] i_res_hist
);

    localparam int SIZE = 2**IWIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [IWIDTH-1:0] r_ptr;
    logic [IWIDTH-1:0] w_nextPtr;
    logic              w_clrWe;
    logic              w_active;
    logic              w_sameTarget;
    logic              w_resWe;
    logic              w_specWe;
    logic [HWIDTH-1:0] w_resData;
    logic [HWIDTH-1:0] w_specData;
    logic [HWIDTH-1:0] w_specCur;
    logic [HWIDTH-1:0] w_resCur;
    logic [HWIDTH-1:0] w_lookCur;
    logic              w_unused;

    // Some inputs are unused in certain MODE/SPEC combinations.
    assign w_unused = ^{i_lookup_index, i_spec_index, i_res_index, i_res_hist,
                        i_res_mispredict, i_spec_valid, i_spec_taken, w_clrWe};

    function automatic logic [HWIDTH-1:0] shiftHist(input logic [HWIDTH-1:0] h,
                                                    input logic t);
        return {h[HWIDTH-2:0], t};
    endfunction

    // State register and sweep pointer; reset returns to the start of the sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_nextState;
            r_ptr   <= w_nextPtr;
        end
    end

    // Next-state logic: flush restarts the sweep; the sweep advances on enabled cycles.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_clrWe     = 1'b0;
        if (i_flush) begin
            w_nextState = CLEAR;
            w_nextPtr   = '0;
        end else if (i_en && (r_state == CLEAR)) begin
            w_clrWe   = 1'b1;
            w_nextPtr = r_ptr + 1'b1;
            if (r_ptr == IWIDTH'(SIZE - 1)) begin
                w_nextState = READY;
            end
        end
    end

    assign w_active     = (r_state == READY) && i_en && !i_flush;
    assign w_sameTarget = (MODE == 1) || (i_res_index == i_spec_index);

    // Update arbitration: a repair beats a speculative shift of the same target.
    always_comb begin
        w_resWe    = 1'b0;
        w_specWe   = 1'b0;
        w_resData  = shiftHist(w_resCur, i_res_taken);
        w_specData = shiftHist(w_specCur, i_spec_taken);
        if (SPEC != 0) begin
            w_resWe   = w_active && i_res_valid && i_res_mispredict;
            w_resData = shiftHist(i_res_hist, i_res_taken);
            w_specWe  = w_active && i_spec_valid && !(w_resWe && w_sameTarget);
        end else begin
            w_resWe   = w_active && i_res_valid;
        end
    end

    generate
        if (MODE == 1) begin : g_global
            logic [HWIDTH-1:0] r_glob;

            assign w_specCur = r_glob;
            assign w_resCur  = r_glob;
            assign w_lookCur = r_glob;

            // Global history register; flush clears it along with the sweep.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_glob <= '0;
                end else if (i_flush) begin
                    r_glob <= '0;
                end else if (w_resWe) begin
                    r_glob <= w_resData;
                end else if (w_specWe) begin
                    r_glob <= w_specData;
                end
            end
        end else begin : g_local
            logic [HWIDTH-1:0] r_tb [SIZE];

            assign w_specCur = r_tb[i_spec_index];
            assign w_resCur  = r_tb[i_res_index];
            assign w_lookCur = r_tb[i_lookup_index];

            // History table: sweep clear, speculative shift and resolve write ports.
            always_ff @(posedge clk) begin
                if (w_clrWe) begin
                    r_tb[r_ptr] <= '0;
                end
                if (w_specWe) begin
                    r_tb[i_spec_index] <= w_specData;
                end
                if (w_resWe) begin
                    r_tb[i_res_index] <= w_resData;
                end
            end
        end
    endgenerate

    assign o_ready       = (r_state == READY);
    assign o_lookup_hist = (r_state == READY) ? w_lookCur : '0;

endmodule

// File: tb/tb_bht_spec.sv
// Testbench for bht_spec: three instances (local/speculative, local/resolve-only,
// global/speculative) share stimulus; each check selects the relevant instance.
module tb_bht_spec;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_en;
    logic       i_flush;
    logic [5:0] i_lookup_index;
    logic       i_spec_valid;
    logic [5:0] i_spec_index;
    logic       i_spec_taken;
    logic       i_res_valid;
    logic [5:0] i_res_index;
    logic       i_res_taken;
    logic       i_res_mispredict;
    logic [3:0] i_res_hist;

    logic       readyA, readyB, readyC;
    logic [3:0] histA, histB, histC;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       sv;
        logic [5:0] si;
        logic       st;
        logic       rv;
        logic [5:0] ri;
        logic       rt;
        logic       rm;
        logic [3:0] rh;
        int         sel;
        logic [5:0] li;
        logic [3:0] exp;
        int         id;
    } vec_t;

    vec_t vecs [20];
    vec_t expQ [$];

    bht_spec #(.IWIDTH(6), .HWIDTH(4), .MODE(0), .SPEC(1)) dutA (
        .clk(clk), .reset(reset), .i_en(i_en), .i_flush(i_flush), .o_ready(readyA),
        .i_lookup_index(i_lookup_index), .o_lookup_hist(histA),
        .i_spec_valid(i_spec_valid), .i_spec_index(i_spec_index), .i_spec_taken(i_spec_taken),
        .i_res_valid(i_res_valid), .i_res_index(i_res_index), .i_res_taken(i_res_taken),
        .i_res_mispredict(i_res_mispredict), .i_res_hist(i_res_hist));

    bht_spec #(.IWIDTH(6), .HWIDTH(4), .MODE(0), .SPEC(0)) dutB (
        .clk(clk), .reset(reset), .i_en(i_en), .i_flush(i_flush), .o_ready(readyB),
        .i_lookup_index(i_lookup_index), .o_lookup_hist(histB),
        .i_spec_valid(i_spec_valid), .i_spec_index(i_spec_index), .i_spec_taken(i_spec_taken),
        .i_res_valid(i_res_valid), .i_res_index(i_res_index), .i_res_taken(i_res_taken),
        .i_res_mispredict(i_res_mispredict), .i_res_hist(i_res_hist));

    bht_spec #(.IWIDTH(6), .HWIDTH(4), .MODE(1), .SPEC(1)) dutC (
        .clk(clk), .reset(reset), .i_en(i_en), .i_flush(i_flush), .o_ready(readyC),
        .i_lookup_index(i_lookup_index), .o_lookup_hist(histC),
        .i_spec_valid(i_spec_valid), .i_spec_index(i_spec_index), .i_spec_taken(i_spec_taken),
        .i_res_valid(i_res_valid), .i_res_index(i_res_index), .i_res_taken(i_res_taken),
        .i_res_mispredict(i_res_mispredict), .i_res_hist(i_res_hist));

    // Free-running clock, posedge at 5, 15, 25 ...
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic sv, input int si, input logic st,
                                input logic rv, input int ri, input logic rt, input logic rm,
                                input logic [3:0] rh, input int sel, input int li,
                                input logic [3:0] exp, input int id);
        vec_t v;
        v.en = en; v.sv = sv; v.si = 6'(si); v.st = st;
        v.rv = rv; v.ri = 6'(ri); v.rt = rt; v.rm = rm; v.rh = rh;
        v.sel = sel; v.li = 6'(li); v.exp = exp; v.id = id;
        return v;
    endfunction

    function automatic logic [3:0] histOf(input int sel);
        if (sel == 0) return histA;
        if (sel == 1) return histB;
        return histC;
    endfunction

    function automatic logic readyOf(input int sel);
        if (sel == 0) return readyA;
        if (sel == 1) return readyB;
        return readyC;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        i_en             = 1'b1;
        i_flush          = 1'b0;
        i_spec_valid     = 1'b0;
        i_spec_index     = '0;
        i_spec_taken     = 1'b0;
        i_res_valid      = 1'b0;
        i_res_index      = '0;
        i_res_taken      = 1'b0;
        i_res_mispredict = 1'b0;
        i_res_hist       = '0;
    endtask

    // Drive one vector for one clock edge and queue its expected lookup result.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        i_en             = v.en;
        i_spec_valid     = v.sv;
        i_spec_index     = v.si;
        i_spec_taken     = v.st;
        i_res_valid      = v.rv;
        i_res_index      = v.ri;
        i_res_taken      = v.rt;
        i_res_mispredict = v.rm;
        i_res_hist       = v.rh;
        expQ.push_back(v);
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    // Pop the oldest expectation and compare the selected instance's lookup.
    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            checkVal("scoreboardEmpty", 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            i_lookup_index = e.li;
            #1;
            checkVal($sformatf("vec%0d_dut%0d_idx%0d", e.id, e.sel, e.li), 32'(histOf(e.sel)), 32'(e.exp));
        end
    endtask

    // Count clock edges until the selected instance reports ready (bounded).
    task automatic waitReady(input int sel, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!readyOf(sel) && cnt < 200);
    endtask

    task automatic readCheck(input string name, input int sel, input int idx, input logic [3:0] exp);
        i_lookup_index = 6'(idx);
        #1;
        checkVal(name, 32'(histOf(sel)), 32'(exp));
    endtask

    initial begin
        int cnt;

        // Vector table: local speculative, collision, resolve-only, global mode.
        vecs[0]  = mk(1, 1, 5, 1, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b0001, 0);
        vecs[1]  = mk(1, 1, 5, 1, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b0011, 1);
        vecs[2]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b0110, 2);
        vecs[3]  = mk(1, 1, 5, 1, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b1101, 3);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 6, 4'b0000, 4);
        vecs[5]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b1101, 5);
        vecs[6]  = mk(1, 1, 5, 1, 1, 5, 0, 1, 4'b0001, 0, 5, 4'b0010, 6);
        vecs[7]  = mk(1, 0, 0, 0, 1, 5, 1, 0, 4'b1111, 0, 5, 4'b0010, 7);
        vecs[8]  = mk(1, 1, 7, 1, 1, 8, 1, 1, 4'b0011, 0, 7, 4'b0001, 8);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 8, 4'b0111, 9);
        vecs[10] = mk(1, 1, 3, 1, 0, 0, 0, 0, 4'b0000, 1, 3, 4'b0000, 10);
        vecs[11] = mk(1, 1, 3, 1, 0, 0, 0, 0, 4'b0000, 1, 3, 4'b0000, 11);
        vecs[12] = mk(1, 0, 0, 0, 1, 3, 1, 0, 4'b0000, 1, 3, 4'b0001, 12);
        vecs[13] = mk(1, 0, 0, 0, 1, 3, 1, 1, 4'b1010, 1, 3, 4'b0011, 13);
        vecs[14] = mk(1, 0, 0, 0, 1, 3, 0, 0, 4'b0000, 1, 3, 4'b0110, 14);
        vecs[15] = mk(1, 1, 2, 1, 0, 0, 0, 0, 4'b0000, 2, 40, 4'b0001, 15);
        vecs[16] = mk(1, 1, 9, 1, 0, 0, 0, 0, 4'b0000, 2, 0, 4'b0011, 16);
        vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2, 63, 4'b0011, 17);
        vecs[18] = mk(1, 1, 9, 1, 1, 4, 0, 1, 4'b0101, 2, 17, 4'b1010, 18);
        vecs[19] = mk(1, 0, 0, 0, 1, 12, 1, 0, 4'b0000, 2, 5, 4'b1010, 19);

        clearInputs();
        i_lookup_index = '0;
        reset = 1'b1;
        #1;
        checkVal("resetReadyA", 32'(readyA), 32'd0);
        checkVal("resetHistA", 32'(histA), 32'd0);

        // Plain sweep after reset: ready on the 64th enabled edge.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        waitReady(0, cnt);
        checkVal("sweepCyclesA", 32'(cnt), 32'd64);
        checkVal("sweepReadyC", 32'(readyC), 32'd1);
        readCheck("clearedIdx0", 0, 0, 4'b0000);
        readCheck("clearedIdx17", 0, 17, 4'b0000);
        readCheck("clearedIdx63", 0, 63, 4'b0000);

        // Mid-operation reset, then a sweep with a 10-cycle enable gap.
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkVal("midResetReadyA", 32'(readyA), 32'd0);
        checkVal("midResetReadyC", 32'(readyC), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        i_en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        i_en = 1'b1;
        checkVal("enGapStillClear", 32'(readyA), 32'd0);
        waitReady(0, cnt);
        checkVal("enGapRemaining", 32'(cnt), 32'd44);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Fresh state for global-mode vectors.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        waitReady(2, cnt);
        checkVal("sweepCyclesC", 32'(cnt), 32'd64);

        for (int i = 15; i < 20; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Load entry 5 = 1101, then flush while READY.
        applyStimulus(mk(1, 1, 5, 1, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b0001, 20));
        checkOutput();
        applyStimulus(mk(1, 1, 5, 1, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b0011, 21));
        checkOutput();
        applyStimulus(mk(1, 1, 5, 0, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b0110, 22));
        checkOutput();
        applyStimulus(mk(1, 1, 5, 1, 0, 0, 0, 0, 4'b0000, 0, 5, 4'b1101, 23));
        checkOutput();

        @(negedge clk);
        i_flush = 1'b1;
        i_en    = 1'b0;
        @(posedge clk);
        #1;
        checkVal("flushReady", 32'(readyA), 32'd0);
        readCheck("flushHistDuringClear", 0, 5, 4'b0000);

        // Sweep after flush; a mispredict resolve to entry 5 lands after the sweep passed it.
        cnt = 0;
        do begin
            @(negedge clk);
            clearInputs();
            if (cnt == 30) begin
                i_res_valid      = 1'b1;
                i_res_index      = 6'd5;
                i_res_taken      = 1'b1;
                i_res_mispredict = 1'b1;
                i_res_hist       = 4'b1111;
            end
            @(posedge clk);
            #1;
            cnt++;
        end while (!readyA && cnt < 200);
        clearInputs();
        checkVal("flushSweepCycles", 32'(cnt), 32'd64);
        readCheck("flushClearedIdx5", 0, 5, 4'b0000);
        readCheck("flushClearedIdx9", 0, 9, 4'b0000);
        readCheck("flushGlobalCleared", 2, 0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bht_spec.md
Name: bht_spec

Overview:
- Parametrised branch history tracker for the fetch/branch-predict path; supplies the history pattern that indexes the PHT.
- Supports local (per-entry) and global history modes.
- Speculative mode shifts history at predict time and repairs it from a resolve-time snapshot on a mispredict; non-speculative mode updates only at resolve.
- Replaces a bulk-array reset with a sequential clear sweep, also triggered by flush.

Parameters:
- IWIDTH, 6, index width; table depth SIZE = 2**IWIDTH.
- HWIDTH, 4, history width per entry; must be >= 2.
- MODE, 0, 0 = local history table (one entry per index); 1 = single global history register, index ignored.
- SPEC, 1, 1 = speculative update at predict plus repair on mispredict; 0 = update only at resolve.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  pipeline enable; low freezes all state except flush.
- flush  in  1  restart clear sweep (pipeline flush / context switch).
- ready  out  1  high when table is valid and accepting updates.
- lookup_index  in  IWIDTH  index hashed from fetch PC.
- lookup_hist  out  HWIDTH  current history for lookup_index (global register when MODE=1).
- spec_valid  in  1  predict-time update request (used only when SPEC=1).
- spec_index  in  IWIDTH  entry to update speculatively.
- spec_taken  in  1  predicted direction.
- res_valid  in  1  branch resolved this cycle.
- res_index  in  IWIDTH  resolved branch's entry.
- res_taken  in  1  actual direction.
- res_mispredict  in  1  prediction was wrong (meaningful when res_valid=1).
- res_hist  in  HWIDTH  history snapshot carried with the branch from its lookup.

Behaviour:
- Read path: lookup_hist is combinational from stored state, with no write bypass. A write at edge N is visible from cycle N+1.
- During CLEAR, lookup_hist = 0.
- State machine: CLEAR, READY.
  - Reset: state=CLEAR, ptr=0, global register=0, ready=0.
  - CLEAR with en=1: each cycle write 0 to tb[ptr], ptr++. The cycle that writes entry SIZE-1 moves to READY.
  - ready=1 exactly SIZE enabled cycles after reset deasserts. CLEAR runs SIZE cycles in both modes.
  - flush=1 in any state (en ignored): next state CLEAR, ptr=0, global register=0.
  - Flush during CLEAR restarts the sweep from 0.
  - While in CLEAR, spec_valid and res_valid are ignored.
- Shift rule: shift(h, t) = {h[HWIDTH-2:0], t}.
- READY, SPEC=1, en=1:
  - spec_valid: target = shift(target, spec_taken), where target is tb[spec_index] (MODE=0) or the global register (MODE=1).
  - res_valid & res_mispredict: target = shift(res_hist, res_taken), using res_index for MODE=0.
  - res_valid & !res_mispredict: no state change.
- READY, SPEC=0, en=1:
  - spec_valid is ignored.
  - res_valid: target = shift(current target, res_taken), regardless of res_mispredict.
- Collision (SPEC=1), same cycle:
  - A repair and a spec update to the same entry (always the same entry when MODE=1): the repair wins and the spec update is dropped.
  - Different entries with MODE=0: both are written.
- en=0: no table, register, ptr or state change; flush still acts.
- Reset asserted mid-operation: immediate return to CLEAR, ptr=0, ready=0. Table contents are not reset directly; the sweep clears them.
- Index wrap: ptr wraps from SIZE-1; no overflow state.

Test Plan:
- Defaults, deassert reset, en=1: ready=0 for 64 cycles, ready=1 on cycle 64; lookup_hist=0 for indices 0, 17, 63. Hold en=0 for 10 cycles mid-sweep: ready is delayed by 10.
- SPEC=1, MODE=0: spec updates at index 5 with taken sequence 1,1,0,1 -> lookup_hist(5)=4'b1101; lookup_hist(6)=0.
- Repair: res_valid, res_mispredict=1, res_index=5, res_hist=4'b0001, res_taken=0, with spec_valid to index 5 in the same cycle -> entry 5 = 4'b0010 next cycle. Non-mispredict resolve leaves it unchanged.
- SPEC=0: spec_valid pulses at index 3 have no effect; res_valid at index 3 with taken 1,1,0 -> 4'b0110.
- MODE=1: spec taken at index 2, then spec taken at index 9 -> lookup_hist=4'b0011 for any lookup_index.
- Flush while READY with entry 5 = 4'b1101: ready=0 the next cycle and for 64 cycles, then lookup_hist(5)=0; a res_valid during CLEAR is ignored.
